// File: rtl/audio_pkg.sv
// Shared audio/FFT definitions: spectrum word layout, widths and the peak-finder state encoding.
package audio_pkg;

   localparam int unsigned FFT_DW     = 14;
   localparam int unsigned FFT_ADDR_W = 10;
   localparam int unsigned MAG_W      = 28;

   typedef enum logic [1:0] {
      PF_IDLE,
      PF_SCAN,
      PF_DRAIN,
      PF_DONE
   } pf_state_t;

   // Packed spectrum word is {real, imag}, both two's complement.
   function automatic logic signed [FFT_DW-1:0] spec_re(input logic [2*FFT_DW-1:0] w);
      return w[2*FFT_DW-1:FFT_DW];
   endfunction

   function automatic logic signed [FFT_DW-1:0] spec_im(input logic [2*FFT_DW-1:0] w);
      return w[FFT_DW-1:0];
   endfunction

endpackage

// File: rtl/mag_sq_pipe.sv
// Two-stage |X|^2 pipeline: registered signed squares, then registered unsigned sum.
// A valid bit and tag travel alongside so callers can keep per-sample context.
module mag_sq_pipe #(
   parameter int unsigned DW    = 14,
   parameter int unsigned TAG_W = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_i,
   input  logic [TAG_W-1:0]     tag_i,
   input  logic signed [DW-1:0] re_i,
   input  logic signed [DW-1:0] im_i,
   output logic                 valid_o,
   output logic [TAG_W-1:0]     tag_o,
   output logic [2*DW-1:0]      mag_o
);

   logic signed [2*DW-2:0] re_x, im_x;
   logic [2*DW-2:0]        sqr_d, sqi_d, sqr_q, sqi_q;
   logic                   v1_q, v2_q;
   logic [TAG_W-1:0]       tag1_q, tag2_q;
   logic [2*DW-1:0]        mag_d, mag_q;

   // 2*DW-1 bits hold (-2^(DW-1))^2 = 2^(2*DW-2) when read as unsigned.
   always_comb begin
      re_x  = {{(DW-1){re_i[DW-1]}}, re_i};
      im_x  = {{(DW-1){im_i[DW-1]}}, im_i};
      sqr_d = re_x * re_x;
      sqi_d = im_x * im_x;
      mag_d = {1'b0, sqr_q} + {1'b0, sqi_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         tag1_q <= '0;
         tag2_q <= '0;
         sqr_q  <= '0;
         sqi_q  <= '0;
         mag_q  <= '0;
      end else begin
         v1_q   <= valid_i;
         tag1_q <= tag_i;
         sqr_q  <= sqr_d;
         sqi_q  <= sqi_d;
         v2_q   <= v1_q;
         tag2_q <= tag1_q;
         mag_q  <= mag_d;
      end
   end

   assign valid_o = v2_q;
   assign tag_o   = tag2_q;
   assign mag_o   = mag_q;

endmodule

// File: rtl/fft_peak_finder.sv
// Scans a bin range of the FFT result RAM and reports the strongest bin, its |X|^2,
// and whether that power reaches the threshold latched at start.
module fft_peak_finder
   import audio_pkg::*;
#(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned DW      = 14,
   parameter int unsigned MIN_BIN = 1,
   parameter int unsigned MAX_BIN = 511,
   parameter int unsigned RD_LAT  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2*DW-1:0]   thresh,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [2*DW-1:0]   rd_q,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] peak_bin,
   output logic [2*DW-1:0]   peak_mag,
   output logic              peak_valid
);

   localparam int unsigned CNT_W = $clog2(RD_LAT + 2) + 1;

   pf_state_t         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2*DW-1:0]   thresh_q, thresh_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [RD_LAT-1:0] tv_q;
   logic [ADDR_W-1:0] ti_q [RD_LAT];

   logic              p_valid;
   logic [ADDR_W-1:0] p_bin;
   logic [2*DW-1:0]   p_mag;

   logic              first_q, first_d;
   logic [ADDR_W-1:0] run_bin_q, run_bin_d, pb_q, pb_d;
   logic [2*DW-1:0]   run_mag_q, run_mag_d, pm_q, pm_d;
   logic              pv_q, pv_d;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      thresh_d = thresh_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         PF_IDLE: if (start) begin
            state_d  = PF_SCAN;
            addr_d   = ADDR_W'(MIN_BIN);
            thresh_d = thresh;
         end
         PF_SCAN: begin
            cnt_d = '0;
            if (addr_q == ADDR_W'(MAX_BIN)) state_d = PF_DRAIN;
            else                            addr_d  = addr_q + 1'b1;
         end
         // The last issued bin leaves the compare stage RD_LAT+2 cycles after issue.
         PF_DRAIN: if (cnt_q == CNT_W'(RD_LAT + 1)) begin
            state_d = PF_DONE;
            addr_d  = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         PF_DONE: state_d = PF_IDLE;
         default: state_d = PF_IDLE;
      endcase
   end

   mag_sq_pipe #(.DW(DW), .TAG_W(ADDR_W)) u_mag (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (tv_q[RD_LAT-1]),
      .tag_i   (ti_q[RD_LAT-1]),
      .re_i    (rd_q[2*DW-1:DW]),
      .im_i    (rd_q[DW-1:0]),
      .valid_o (p_valid),
      .tag_o   (p_bin),
      .mag_o   (p_mag)
   );

   // Strict greater-than keeps the lower bin on ties; results publish on DONE entry.
   always_comb begin
      first_d   = first_q;
      run_bin_d = run_bin_q;
      run_mag_d = run_mag_q;
      if (state_q == PF_IDLE && start) begin
         first_d = 1'b1;
      end else if (p_valid && (first_q || p_mag > run_mag_q)) begin
         first_d   = 1'b0;
         run_bin_d = p_bin;
         run_mag_d = p_mag;
      end
      pb_d = pb_q;
      pm_d = pm_q;
      pv_d = pv_q;
      if (state_q == PF_DRAIN && state_d == PF_DONE) begin
         pb_d = run_bin_d;
         pm_d = run_mag_d;
         pv_d = (run_mag_d >= thresh_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= PF_IDLE;
         addr_q    <= '0;
         thresh_q  <= '0;
         cnt_q     <= '0;
         tv_q      <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) ti_q[i] <= '0;
         first_q   <= 1'b0;
         run_bin_q <= '0;
         run_mag_q <= '0;
         pb_q      <= '0;
         pm_q      <= '0;
         pv_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         thresh_q  <= thresh_d;
         cnt_q     <= cnt_d;
         tv_q[0]   <= (state_q == PF_SCAN);
         ti_q[0]   <= addr_q;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            tv_q[i] <= tv_q[i-1];
            ti_q[i] <= ti_q[i-1];
         end
         first_q   <= first_d;
         run_bin_q <= run_bin_d;
         run_mag_q <= run_mag_d;
         pb_q      <= pb_d;
         pm_q      <= pm_d;
         pv_q      <= pv_d;
      end
   end

   assign rd_addr    = addr_q;
   assign busy       = (state_q == PF_SCAN) || (state_q == PF_DRAIN);
   assign done       = (state_q == PF_DONE);
   assign peak_bin   = pb_q;
   assign peak_mag   = pm_q;
   assign peak_valid = pv_q;

endmodule
